butterfly_r2_pipe: RTL and testbench
====================================

Name: butterfly_r2_pipe

Overview:
Parametrised radix-2 DIT butterfly for the FFT datapath, and the successor to the fixed 16-bit butterfly.
- Computes yp = xp + xq·W and yq = xp − xq·W, with generic data and twiddle widths.
- Per-transaction scale-by-½, round-half-up, output saturation with a sticky overflow flag, and an inverse (conjugate-twiddle) mode.
- Full valid/ready handshake and a sideband tag, so the stage controller can stall the pipe and track memory addresses.

Parameters:
DW, 16, signed data width of xp/xq/yp/yq components.
TW, 16, signed twiddle width; twiddle format Q1.(TW-1); −1.0 = −2^(TW-1); +1.0 not representable.
TAGW, 8, width of pass-through tag (butterfly address).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
in_valid  in  1  input transaction valid.
in_ready  out  1  block can accept input this cycle.
xp_re, xp_im  in  DW each  upper input, signed.
xq_re, xq_im  in  DW each  lower input, signed.
w_re, w_im  in  TW each  twiddle, signed Q1.(TW-1).
scale  in  1  1 = divide result by 2 (block-floating stage scaling).
inv  in  1  1 = use conj(W) (IFFT).
tag_in  in  TAGW  sideband, passed through unchanged.
out_valid  out  1  output transaction valid.
out_ready  in  1  downstream accepts output.
yp_re, yp_im, yq_re, yq_im  out  DW each  results, signed.
tag_out  out  TAGW  tag aligned with results.
ovf  out  1  sticky: some output component saturated.
ovf_clr  in  1  clears ovf.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high on rst.
- Reset values: all pipeline valid bits 0, out_valid 0, all data/tag outputs 0, ovf 0. Any transactions in flight when rst asserts are discarded.
- Pipeline: 3 register stages S1, S2, S3. Each stage holds a valid bit and data. S3 drives the outputs.
- Stall rule: stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - Accept occurs when in_valid & in_ready.
  - When stall = 0, every stage advances; S1 loads the accepted transaction, or valid = 0 if none is accepted.
  - When stall = 1, all stages hold.
  - Bubbles are not compressed.
  - Outputs stay stable while out_valid & ~out_ready.
- Latency: a transaction accepted at edge k appears on the outputs (out_valid = 1) after edge k+2, with no stall. Throughput is 1 per clock.
- S1 (products):
  - a = xq_re·w_re, b = xq_im·w_im, c = xq_re·w_im, d = xq_im·w_re, each DW+TW bits signed.
  - xp components sign-extended and shifted left by TW−1.
  - scale, inv and tag registered.
- S2 (complex multiply):
  - inv = 0: pr = a − b, pi = c + d.
  - inv = 1: pr = a + b, pi = d − c.
  - Width DW+TW+1. xp, scale and tag delayed one stage.
- S3 (butterfly and requantise):
  - s = xp_al ± p, width DW+TW+2.
  - Shift sh = TW−1+scale. Round half toward +∞: r = (s + 2^(sh−1)) >>> sh.
  - Saturate r to [−2^(DW−1), 2^(DW−1)−1].
- ovf:
  - Set on the S3 load cycle if any of the 4 components saturated.
  - ovf_clr in the same cycle as a new saturation: set wins.
  - Otherwise ovf_clr clears ovf.
  - ovf is held during stall.
- scale, inv and tag are per-transaction and travel with the data. Changing them between back-to-back inputs takes effect exactly on the matching transaction.
- in_valid while in_ready = 0: inputs ignored; upstream must hold.

Test Plan:
1. DW=TW=16, scale=0, inv=0, xp=(1000,0), xq=(500,0), W=(−32768,0) → yp=(500,0), yq=(1500,0), out_valid after edge k+2, ovf=0.
2. Same as 1 with scale=1 → yp=(250,0), yq=(750,0). Rounding: xp=(3,−3), xq=0, W=(−32768,0), scale=1 → yp=yq=(2,−1).
3. inv: xp=0, xq=(100,0), W=(0,−32768). inv=0 → yp=(0,−100), yq=(0,100). inv=1 → yp=(0,100), yq=(0,−100).
4. Saturation: xp=(30000,0), xq=(30000,0), W=(−32768,0), scale=0 → yq_re=32767, yp_re=0, ovf=1. ovf stays 1 through later clean data until ovf_clr pulses, then 0. ovf_clr coincident with a new saturation → ovf remains 1.
5. Backpressure: stream tags 1..6 back-to-back with out_ready=0 from cycle 2 → in_ready drops once out_valid=1. Outputs hold tag 1 stable. Releasing out_ready delivers tags 1..6 in order, none lost or duplicated. Random out_ready toggling is checked against a reference model.
6. Reset mid-stream: assert rst with 3 transactions in flight → next cycle out_valid=0, all outputs 0, ovf=0, in_ready=1. The first transaction after reset emerges with correct latency.

Source files
------------

// File: rtl/butterfly_r2_pipe.sv
// Radix-2 DIT butterfly, three-stage pipeline with a valid/ready handshake.
// It computes yp = xp + xq*W and yq = xp - xq*W.
// Each transaction carries its own scale-by-half, conjugate-twiddle (inverse) and tag.
// Outputs are rounded half-up and saturated; any saturation sets a sticky ovf flag.
module butterfly_r2_pipe #(
    parameter int DW   = 16,
    parameter int TW   = 16,
    parameter int TAGW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] xp_re,
    input  logic signed [DW-1:0] xp_im,
    input  logic signed [DW-1:0] xq_re,
    input  logic signed [DW-1:0] xq_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    input  logic                 scale,
    input  logic                 inv,
    input  logic [TAGW-1:0]      tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] yp_re,
    output logic signed [DW-1:0] yp_im,
    output logic signed [DW-1:0] yq_re,
    output logic signed [DW-1:0] yq_im,
    output logic [TAGW-1:0]      tag_out,
    output logic                 ovf,
    input  logic                 ovf_clr
);

    localparam int PW = DW + TW;      // partial products, aligned xp
    localparam int MW = DW + TW + 1;  // complex product
    localparam int SW = DW + TW + 2;  // butterfly sum
    localparam int RW = SW + 1;       // sum plus rounding constant

    localparam logic signed [RW-1:0] MAXV = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = ~MAXV;

    logic stall;
    logic accept;

    // Stage 1 registers
    logic                 s1_valid;
    logic signed [PW-1:0] s1_a, s1_b, s1_c, s1_d;
    logic signed [PW-1:0] s1_xp_re, s1_xp_im;
    logic                 s1_scale, s1_inv;
    logic [TAGW-1:0]      s1_tag;

    // Stage 2 registers
    logic                 s2_valid;
    logic signed [MW-1:0] s2_pr, s2_pi;
    logic signed [PW-1:0] s2_xp_re, s2_xp_im;
    logic                 s2_scale;
    logic [TAGW-1:0]      s2_tag;

    // Stage 3 combinational results
    logic signed [SW-1:0] sp_re, sp_im, sq_re, sq_im;
    logic [DW:0]          rq_pr, rq_pi, rq_qr, rq_qi;
    logic                 sat_any;

    // Round half toward +inf, shift by TW-1+sc, then clamp to DW bits.
    // The result is {saturated, value}.
    function automatic logic [DW:0] requant(input logic signed [SW-1:0] s, input logic sc);
        logic signed [RW-1:0] half;
        logic signed [RW-1:0] t;
        logic signed [RW-1:0] r;
        half = '0;
        if (sc) half[TW-1] = 1'b1;
        else    half[TW-2] = 1'b1;
        t = RW'(s) + half;
        r = sc ? (t >>> TW) : (t >>> (TW-1));
        if (r > MAXV)      return {1'b1, MAXV[DW-1:0]};
        else if (r < MINV) return {1'b1, MINV[DW-1:0]};
        else               return {1'b0, r[DW-1:0]};
    endfunction

    // Handshake: the whole pipe freezes when the output is held off.
    always_comb begin
        stall    = out_valid & ~out_ready;
        in_ready = ~stall;
        accept   = in_valid & in_ready;
    end

    // S1: partial products and xp alignment
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_c     <= '0;
            s1_d     <= '0;
            s1_xp_re <= '0;
            s1_xp_im <= '0;
            s1_scale <= 1'b0;
            s1_inv   <= 1'b0;
            s1_tag   <= '0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_a     <= PW'(xq_re) * PW'(w_re);
                s1_b     <= PW'(xq_im) * PW'(w_im);
                s1_c     <= PW'(xq_re) * PW'(w_im);
                s1_d     <= PW'(xq_im) * PW'(w_re);
                s1_xp_re <= {xp_re[DW-1], xp_re, {(TW-1){1'b0}}};
                s1_xp_im <= {xp_im[DW-1], xp_im, {(TW-1){1'b0}}};
                s1_scale <= scale;
                s1_inv   <= inv;
                s1_tag   <= tag_in;
            end
        end
    end

    // S2: complex multiply; inverse mode uses conj(W)
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_pr    <= '0;
            s2_pi    <= '0;
            s2_xp_re <= '0;
            s2_xp_im <= '0;
            s2_scale <= 1'b0;
            s2_tag   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_pr    <= s1_inv ? (MW'(s1_a) + MW'(s1_b)) : (MW'(s1_a) - MW'(s1_b));
                s2_pi    <= s1_inv ? (MW'(s1_d) - MW'(s1_c)) : (MW'(s1_c) + MW'(s1_d));
                s2_xp_re <= s1_xp_re;
                s2_xp_im <= s1_xp_im;
                s2_scale <= s1_scale;
                s2_tag   <= s1_tag;
            end
        end
    end

    // S3 input: butterfly sums and requantisation of all four components
    always_comb begin
        sp_re   = SW'(s2_xp_re) + SW'(s2_pr);
        sp_im   = SW'(s2_xp_im) + SW'(s2_pi);
        sq_re   = SW'(s2_xp_re) - SW'(s2_pr);
        sq_im   = SW'(s2_xp_im) - SW'(s2_pi);
        rq_pr   = requant(sp_re, s2_scale);
        rq_pi   = requant(sp_im, s2_scale);
        rq_qr   = requant(sq_re, s2_scale);
        rq_qi   = requant(sq_im, s2_scale);
        sat_any = rq_pr[DW] | rq_pi[DW] | rq_qr[DW] | rq_qi[DW];
    end

    // S3: output register and sticky overflow (a new saturation beats a clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            yp_re     <= '0;
            yp_im     <= '0;
            yq_re     <= '0;
            yq_im     <= '0;
            tag_out   <= '0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                yp_re   <= rq_pr[DW-1:0];
                yp_im   <= rq_pi[DW-1:0];
                yq_re   <= rq_qr[DW-1:0];
                yq_im   <= rq_qi[DW-1:0];
                tag_out <= s2_tag;
            end
            if (s2_valid && sat_any) ovf <= 1'b1;
            else if (ovf_clr)        ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Scoreboard bench for butterfly_r2_pipe.
// The driver pushes reference results computed with plain integer arithmetic.
// A negedge monitor pops and compares them on every output transfer.
module tb_butterfly_r2_pipe;
    localparam int DW   = 16;
    localparam int TW   = 16;
    localparam int TAGW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] xp_re, xp_im, xq_re, xq_im;
    logic signed [TW-1:0] w_re, w_im;
    logic                 scale, inv;
    logic [TAGW-1:0]      tag_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] yp_re, yp_im, yq_re, yq_im;
    logic [TAGW-1:0]      tag_out;
    logic                 ovf;
    logic                 ovf_clr;

    always #5 clk = ~clk;

    butterfly_r2_pipe #(.DW(DW), .TW(TW), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .xp_re(xp_re), .xp_im(xp_im), .xq_re(xq_re), .xq_im(xq_im),
        .w_re(w_re), .w_im(w_im), .scale(scale), .inv(inv), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .yp_re(yp_re), .yp_im(yp_im), .yq_re(yq_re), .yq_im(yq_im),
        .tag_out(tag_out), .ovf(ovf), .ovf_clr(ovf_clr)
    );

    typedef struct {
        int ypr, ypi, yqr, yqi;
        int tag;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_mon;
    int   checks   = 0;
    int   failures = 0;
    bit   ovf_acc  = 0;
    bit   mon_en   = 0;
    int   bp_mode  = 0;   // 0: ready high, 1: ready low, 2: random
    bit   held     = 0;
    logic [4*DW+TAGW-1:0] hold_vec;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Floor division, so that rounding half-up is floor((s + d/2) / d).
    function automatic longint fdiv(input longint v, input longint d);
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic int rq(input longint s, input bit sc, inout bit sat);
        longint d;
        longint q;
        d = longint'(1) << (TW - 1 + int'(sc));
        q = fdiv(s + d / 2, d);
        if (q > 32767)  begin sat = 1; return 32767;  end
        if (q < -32768) begin sat = 1; return -32768; end
        return int'(q);
    endfunction

    function automatic exp_t model(input int xpr, xpi, xqr, xqi, wr, wi,
                                   input bit sc, iv, input int tg);
        exp_t   e;
        longint wie, pr, pi, base;
        bit     sat;
        sat  = 0;
        wie  = iv ? -longint'(wi) : longint'(wi);
        pr   = longint'(xqr) * wr - longint'(xqi) * wie;
        pi   = longint'(xqr) * wie + longint'(xqi) * wr;
        base = longint'(1) << (TW - 1);
        e.ypr = rq(xpr * base + pr, sc, sat);
        e.ypi = rq(xpi * base + pi, sc, sat);
        e.yqr = rq(xpr * base - pr, sc, sat);
        e.yqi = rq(xpi * base - pi, sc, sat);
        e.tag = tg & 8'hff;
        e.sat = sat;
        return e;
    endfunction

    function automatic int r16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    // Called just after a rising edge. Returns just after the edge that accepted the transaction.
    task automatic send(input int xpr, xpi, xqr, xqi, wr, wi, input bit sc, iv, input int tg);
        xp_re = 16'(xpr); xp_im = 16'(xpi);
        xq_re = 16'(xqr); xq_im = 16'(xqi);
        w_re  = 16'(wr);  w_im  = 16'(wi);
        scale = sc; inv = iv; tag_in = 8'(tg);
        in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(xpr, xpi, xqr, xqi, wr, wi, sc, iv, tg));
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL send_timeout actual=no_accept required=accept tag=%0d", tg);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            if (exp_q.size() == 0) begin @(posedge clk); #1; return; end
            @(posedge clk); #1;
        end
        checks++; failures++;
        $display("FAIL drain_timeout actual=%0d required=0 pending", exp_q.size());
    endtask

    // Call right after send() on an empty pipe: out_valid must rise exactly after edge k+2.
    task automatic lat_check(input string name);
        @(negedge clk); chk({name, "_lat_k"},  longint'(out_valid), 0);
        @(negedge clk); chk({name, "_lat_k1"}, longint'(out_valid), 0);
        @(negedge clk); chk({name, "_lat_k2"}, longint'(out_valid), 1);
        @(posedge clk); #1;
    endtask

    // Downstream ready generator
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: held outputs must stay stable; each transfer is checked against the scoreboard
    always @(negedge clk) begin
        if (rst || !mon_en) begin
            held = 0;
        end else begin
            if (held) begin
                checks++;
                if ({yp_re, yp_im, yq_re, yq_im, tag_out} !== hold_vec) begin
                    failures++;
                    $display("FAIL hold_stable actual=%h required=%h",
                             {yp_re, yp_im, yq_re, yq_im, tag_out}, hold_vec);
                end
            end
            held = 0;
            if (out_valid) begin
                if (!out_ready) begin
                    held = 1;
                    hold_vec = {yp_re, yp_im, yq_re, yq_im, tag_out};
                end else if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output actual=tag%0d required=none", tag_out);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("tag",   longint'(tag_out), e_mon.tag);
                    chk("yp_re", longint'(yp_re), e_mon.ypr);
                    chk("yp_im", longint'(yp_im), e_mon.ypi);
                    chk("yq_re", longint'(yq_re), e_mon.yqr);
                    chk("yq_im", longint'(yq_im), e_mon.yqi);
                    ovf_acc = ovf_acc | e_mon.sat;
                    chk("ovf_sticky", longint'(ovf), longint'(ovf_acc));
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; ovf_clr = 1'b0; out_ready = 1'b1;
        xp_re = '0; xp_im = '0; xq_re = '0; xq_im = '0;
        w_re = '0; w_im = '0; scale = 1'b0; inv = 1'b0; tag_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_in_ready",  longint'(in_ready), 1);
        chk("rst_ovf",       longint'(ovf), 0);
        chk("rst_yp_re",     longint'(yp_re), 0);
        chk("rst_tag_out",   longint'(tag_out), 0);
        rst = 1'b0;
        mon_en = 1;
        @(posedge clk); #1;

        // Basic butterfly and latency
        send(1000, 0, 500, 0, -32768, 0, 0, 0, 1);
        lat_check("basic");
        // Scaling and rounding
        send(1000, 0, 500, 0, -32768, 0, 1, 0, 2);
        send(3, -3, 0, 0, -32768, 0, 1, 0, 3);
        // Inverse mode, with settings alternating back-to-back
        send(0, 0, 100, 0, 0, -32768, 0, 0, 4);
        send(0, 0, 100, 0, 0, -32768, 0, 1, 5);
        send(0, 0, 100, 0, 0, -32768, 1, 0, 6);
        drain();

        // Saturation and the sticky flag
        send(30000, 0, 30000, 0, -32768, 0, 0, 0, 7);
        send(10, 20, 30, 40, 1000, -2000, 0, 0, 8);
        drain();
        chk("ovf_held", longint'(ovf), 1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        ovf_acc = 0;
        chk("ovf_cleared", longint'(ovf), 0);
        send(30000, 0, 30000, 0, -32768, 0, 0, 0, 9);
        @(posedge clk); #1;
        ovf_clr = 1'b1;          // spans the edge that loads the saturating result
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", longint'(ovf), 1);
        drain();

        // Backpressure: ready low before the first result arrives
        bp_mode = 1; out_ready = 1'b0;
        fork
            begin
                for (int t = 1; t <= 6; t++)
                    send(t * 100, -t * 50, t * 37, 11 * t, 20000, -12000, t % 2, 0, t);
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", longint'(in_ready), 0);
                chk("bp_out_valid",    longint'(out_valid), 1);
                chk("bp_tag_hold",     longint'(tag_out), 1);
                @(posedge clk); #1;
                bp_mode = 0; out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three transactions in flight, the oldest one saturating
        send(30000, 0, 30000, 0, -32768, 0, 0, 0, 8'hA1);
        send(1, 2, 3, 4, 5, 6, 0, 0, 8'hA2);
        send(7, 8, 9, 10, 11, 12, 0, 0, 8'hA3);
        chk("pre_rst_ovf", longint'(ovf), 1);
        rst = 1'b1;
        exp_q.delete();
        ovf_acc = 0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_ovf",       longint'(ovf), 0);
        chk("mid_rst_in_ready",  longint'(in_ready), 1);
        chk("mid_rst_yq_re",     longint'(yq_re), 0);
        chk("mid_rst_tag",       longint'(tag_out), 0);
        rst = 1'b0;
        send(-1234, 567, 890, -321, 23170, -23170, 0, 1, 8'hB0);
        lat_check("post_rst");
        drain();

        // Randomised traffic with random backpressure
        bp_mode = 2;
        for (int i = 0; i < 400; i++) begin
            int wr, wi;
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            wr = ($urandom_range(0, 7) == 0) ? -32768 : r16();
            wi = ($urandom_range(0, 7) == 0) ? -32768 : r16();
            send(r16(), r16(), r16(), r16(), wr, wi,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), i);
        end
        bp_mode = 0; out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
